// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display scheduler: page encoding,
// digit count and the active-low hex font.
package display_pkg;

    // Debug word shown on the display; values match the page output index.
    typedef enum logic [1:0] {
        PAGE_PC    = 2'd0,
        PAGE_VALUE = 2'd1,
        PAGE_X     = 2'd2,
        PAGE_Y     = 2'd3
    } page_e;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

    // Blanked display levels (all lines are active-low).
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;
    localparam logic [6:0]            SEG_OFF = 7'h7F;

    // Segment patterns {g,f,e,d,c,b,a}, active-low, indexed by nibble value.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup into the shared font.
    assign seg = SEG_FONT[nibble];

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 8-digit display among four debug words. A page FSM rotates
// on a dwell timer or a user "next" pulse; digits are scanned at a fixed rate
// and the shown word is snapshotted only at frame boundaries or page changes.
module display_scheduler
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int DWELL_CYCLES = 100000000
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           value_in,
    input  logic [31:0]           coord_x_in,
    input  logic [31:0]           coord_y_in,
    input  logic                  hold,
    input  logic                  next,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [1:0]            page
);

    localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DWELL_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
    localparam logic [DWELL_W-1:0]   DWELL_LAST   = DWELL_W'(DWELL_CYCLES - 1);

    page_e                page_q;
    page_e                page_d;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [REFRESH_W-1:0] refresh_cnt;
    logic [DIGIT_W-1:0]   digit_idx;
    logic [31:0]          snapshot;
    logic [31:0]          snap_src;
    logic [3:0]           cur_nibble;
    logic [6:0]           digit_seg;
    logic                 advance;

    // A user pulse and dwell expiry in the same cycle still give one step.
    assign advance = next || ((dwell_cnt == DWELL_LAST) && !hold);

    // Page state register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) page_q <= PAGE_PC;
        else      page_q <= page_d;
    end

    // Next page: step modulo 4 on advance, otherwise stay.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        page_d = page_q;
        if (advance) page_d = page_e'(page_q + 2'd1);
    end

    // Page outputs: index and the word to snapshot (the new page on an advance,
    // the current page at a frame wrap -- page_d covers both).
    always_comb begin
        page = page_q;
        unique case (page_d)
            PAGE_PC:    snap_src = pc_in;
            PAGE_VALUE: snap_src = value_in;
            PAGE_X:     snap_src = coord_x_in;
            PAGE_Y:     snap_src = coord_y_in;
            default:    snap_src = pc_in;
        endcase
    end

    // Dwell timer, digit scan and frame snapshot; an advance restarts the scan.
    // NOTE: the snapshot is reset along with the counters so the first frame
    // after reset is a defined all-zero word rather than power-up garbage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt   <= '0;
            refresh_cnt <= '0;
            digit_idx   <= '0;
            snapshot    <= '0;
        end else if (advance) begin
            dwell_cnt   <= '0;
            refresh_cnt <= '0;
            digit_idx   <= '0;
            snapshot    <= snap_src;
        end else begin
            if (!hold) dwell_cnt <= dwell_cnt + DWELL_W'(1);
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + DIGIT_W'(1);
                if (digit_idx == DIGIT_LAST) snapshot <= snap_src;
            end else begin
                refresh_cnt <= refresh_cnt + REFRESH_W'(1);
            end
        end
    end

    assign cur_nibble = snapshot[{digit_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (digit_seg)
    );

    // Registered pin drivers; dp marks the digit whose index equals the page.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << digit_idx);
            seg <= digit_seg;
            dp  <= ~(digit_idx == {1'b0, page_q});
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with a small display rate:
// directed steps plus randomized traffic against a cycle-level reference model
// derived from elapsed time since the last page change.
module tb_display_scheduler;

    localparam int R     = 4;
    localparam int D     = 64;
    localparam int FRAME = R * 8;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0, value_in = '0, coord_x_in = '0, coord_y_in = '0;
    logic        hold = 1'b0, next = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  page;

    display_scheduler #(.REFRESH_DIV(R), .DWELL_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .value_in   (value_in),
        .coord_x_in (coord_x_in),
        .coord_y_in (coord_y_in),
        .hold       (hold),
        .next       (next),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .page       (page)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: page, cycles since last page change, unheld cycles
    // since last page change, and the word currently on display.
    int          m_page, m_t, m_dwell;
    logic [31:0] m_snap;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    function automatic logic [31:0] src(input int p);
        case (p)
            0:       return pc_in;
            1:       return value_in;
            2:       return coord_x_in;
            default: return coord_y_in;
        endcase
    endfunction

    task automatic model_reset();
        m_page = 0; m_t = 0; m_dwell = 0; m_snap = '0;
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    endtask

    // One rising edge with reset released: outputs reflect the pre-edge view.
    task automatic model_edge();
        int  digit;
        int  nib;
        bit  adv;
        digit = (m_t / R) % 8;
        nib   = int'((m_snap >> (4 * digit)) & 32'hF);
        e_an  = ~(8'd1 << digit);
        e_seg = FONT[nib];
        e_dp  = (digit == m_page) ? 1'b0 : 1'b1;
        adv   = next || (m_dwell == D - 1 && !hold);
        if (adv) begin
            m_page  = (m_page + 1) % 4;
            m_t     = 0;
            m_dwell = 0;
            m_snap  = src(m_page);
        end else begin
            m_t++;
            if (!hold) m_dwell++;
            if (m_t % FRAME == 0) m_snap = src(m_page);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("an",   32'(an),   32'(e_an));
        check("seg",  32'(seg),  32'(e_seg));
        check("dp",   32'(dp),   32'(e_dp));
        check("page", 32'(page), 32'(m_page));
    endtask

    // Advance one clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        model_reset();

        // Reset state held across several edges.
        ticks(3);
        check("rst_an",  32'(an),  32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);

        // Scan and dwell stepping from a clean release.
        pc_in    = 32'h0040_0010;
        value_in = 32'hABCD_1234;
        rst      = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            tick();
            case (n)
                1:   begin check("d0_an", 32'(an), 32'hFE); check("d0_seg", 32'(seg), 32'h40);
                           check("d0_dp", 32'(dp), 32'h0); end
                5:   check("d1_an_first_frame", 32'(an), 32'hFD);
                37:  begin check("d1_an", 32'(an), 32'hFD); check("d1_seg", 32'(seg), 32'h79); end
                53:  begin check("d5_an", 32'(an), 32'hDF); check("d5_seg", 32'(seg), 32'h19); end
                64:  check("dwell_page1", 32'(page), 32'h1);
                65:  begin check("v_d0_an", 32'(an), 32'hFE); check("v_d0_seg", 32'(seg), 32'h19); end
                93:  begin check("v_d7_an", 32'(an), 32'h7F); check("v_d7_seg", 32'(seg), 32'h08); end
                128: check("dwell_page2", 32'(page), 32'h2);
                192: check("dwell_page3", 32'(page), 32'h3);
                256: check("dwell_wrap0", 32'(page), 32'h0);
                default: ;
            endcase
        end

        // Hold freezes paging; single next pulses still step.
        hold = 1'b1;
        ticks(200);
        check("hold_page", 32'(page), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            next = 1'b1;
            tick();
            next = 1'b0;
            check("next_pulse_page", 32'(page), 32'(k));
            ticks(3);
        end

        // next coincident with dwell expiry steps exactly once.
        hold = 1'b0;
        ticks(63);
        check("pre_expiry_page", 32'(page), 32'h3);
        next = 1'b1;
        tick();
        next = 1'b0;
        check("coincident_page", 32'(page), 32'h0);
        tick();
        check("coincident_no_repeat", 32'(page), 32'h0);

        // next held for two cycles steps two pages.
        next = 1'b1;
        ticks(2);
        next = 1'b0;
        check("next_held2_page", 32'(page), 32'h2);

        // Asynchronous reset in the middle of digit 3.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((m_t / R) % 8 == 3 && m_t % R == 1) found = 1'b1;
            else tick();
        end
        check("reach_digit3", 32'(found), 32'h1);
        rst = 1'b0;
        #1;
        check("async_an",   32'(an),   32'hFF);
        check("async_seg",  32'(seg),  32'h7F);
        check("async_dp",   32'(dp),   32'h1);
        check("async_page", 32'(page), 32'h0);
        model_reset();

        // Snapshot isolation: source change mid-frame shows only after the wrap.
        value_in = 32'h1111_1111;
        ticks(2);
        @(negedge clk);
        rst  = 1'b1;
        next = 1'b1;
        tick();
        next = 1'b0;
        check("snap_page1", 32'(page), 32'h1);
        for (int n = 1; n <= 33; n++) begin
            tick();
            case (n)
                12: value_in = 32'h2222_2222;
                17: begin check("snap_d4_an", 32'(an), 32'hEF); check("snap_d4_seg", 32'(seg), 32'h79); end
                29: check("snap_d7_seg", 32'(seg), 32'h79);
                32: check("snap_last_old", 32'(seg), 32'h79);
                33: begin check("snap_new_an", 32'(an), 32'hFE); check("snap_new_seg", 32'(seg), 32'h24); end
                default: ;
            endcase
        end

        // Randomized traffic against the model, with one mid-run reset.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pc_in      = $urandom;
                    1:       value_in   = $urandom;
                    2:       coord_x_in = $urandom;
                    default: coord_y_in = $urandom;
                endcase
            end
            next = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) hold = ~hold;
            if (i == 400) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_model();
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
